// File: rtl/dadda_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined Dadda multiplier.
package dadda_pkg;

  localparam int LATENCY = 3;
  localparam int MAX_W   = 32;

  // Selects which quantity dadda_plan reports for a (stage, column) pair.
  typedef enum int {
    PLAN_HEIGHT,
    PLAN_FA,
    PLAN_HA
  } plan_e;

  // Dadda target heights d_j: 2,3,4,6,9,13,19,28,42 (d_1 = 2, d_j+1 = floor(1.5*d_j)).
  function automatic int dadda_height(input int j);
    int d;
    d = 2;
    for (int k = 1; k < j; k++) d = (d * 3) / 2;
    return d;
  endfunction

  // Number of reduction stages to bring a WIDTH-tall matrix down to two rows.
  function automatic int dadda_num_stages(input int w);
    int j;
    j = 0;
    while (dadda_height(j + 1) < w) j++;
    return j;
  endfunction

  // Replays the whole reduction schedule and reports the height of column c
  // entering stage s, or the number of full/half adders placed in it at stage s.
  // Stage 0 is the raw partial-product matrix; each stage targets the next
  // smaller d_j, scanning columns from the LSB so carries ripple upward.
  function automatic int dadda_plan(input int w, input int s, input int c,
                                    input plan_e what);
    int h  [2*MAX_W];
    int hn [2*MAX_W];
    int ns;
    int d;
    int cprev;
    int e;
    int fa;
    int ha;
    ns = dadda_num_stages(w);
    for (int i = 0; i < 2*MAX_W; i++) begin
      h[i]  = (i < w) ? i + 1 : ((i < 2*w) ? 2*w - 1 - i : 0);
      hn[i] = 0;
    end
    for (int st = 0; st <= ns; st++) begin
      if (st == s && what == PLAN_HEIGHT) return h[c];
      if (st < ns) begin
        d     = dadda_height(ns - st);
        cprev = 0;
        for (int i = 0; i < 2*w; i++) begin
          e  = h[i] + cprev - d;
          fa = (e > 0) ? e / 2 : 0;
          ha = (e > 0) ? e % 2 : 0;
          if (st == s && i == c) return (what == PLAN_FA) ? fa : ha;
          hn[i] = h[i] - 2*fa - ha + cprev;
          cprev = fa + ha;
        end
        for (int i = 0; i < 2*MAX_W; i++) h[i] = hn[i];
      end
    end
    return 0;
  endfunction

  function automatic int dadda_col_height(input int w, input int s, input int c);
    return (c < 0) ? 0 : dadda_plan(w, s, c, PLAN_HEIGHT);
  endfunction

  function automatic int dadda_fa_count(input int w, input int s, input int c);
    return (c < 0) ? 0 : dadda_plan(w, s, c, PLAN_FA);
  endfunction

  function automatic int dadda_ha_count(input int w, input int s, input int c);
    return (c < 0) ? 0 : dadda_plan(w, s, c, PLAN_HA);
  endfunction

endpackage

// File: rtl/dadda_cells.sv
// Arithmetic cells shared by the multiplier: full adder, half adder and a
// parameterised Kogge-Stone adder.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic sum,
  output logic co
);
  assign sum = a ^ b ^ ci;
  assign co  = (a & b) | (ci & (a ^ b));
endmodule

module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic co
);
  assign sum = a ^ b;
  assign co  = a & b;
endmodule

module kogge_stone_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);
  localparam int LV = $clog2(WIDTH);

  logic [WIDTH-1:0] g [LV+1];
  logic [WIDTH-1:0] p [LV+1];

  assign g[0] = a & b;
  assign p[0] = a ^ b;

  // Each level doubles the span of every group (generate, propagate) pair.
  for (genvar gl = 0; gl < LV; gl++) begin : gen_level
    for (genvar gi = 0; gi < WIDTH; gi++) begin : gen_bit
      if (gi >= (1 << gl)) begin : gen_merge
        assign g[gl+1][gi] = g[gl][gi] | (p[gl][gi] & g[gl][gi-(1<<gl)]);
        assign p[gl+1][gi] = p[gl][gi] & p[gl][gi-(1<<gl)];
      end else begin : gen_pass
        assign g[gl+1][gi] = g[gl][gi];
        assign p[gl+1][gi] = p[gl][gi];
      end
    end
  end

  // g[LV][i] is the carry out of bits 0..i, i.e. the carry into bit i+1.
  assign sum = p[0] ^ {g[LV][WIDTH-2:0], 1'b0};
endmodule

// File: rtl/dadda_reduce.sv
// Combinational Dadda tree: AND partial products of two WIDTH-bit magnitudes
// reduced to two 2*WIDTH-bit rows whose sum is the product.
module dadda_reduce
  import dadda_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] row0,
  output logic [2*WIDTH-1:0] row1
);
  localparam int NS = dadda_num_stages(WIDTH);
  localparam int CW = 2 * WIDTH;

  // mat[s][c] holds the bits of column c entering stage s; rows above the
  // column height are tied to zero. sm/cy are adder sums and carries.
  logic [WIDTH-1:0] mat [NS+1][CW];
  logic [WIDTH-1:0] sm  [NS][CW];
  logic [WIDTH-1:0] cy  [NS][CW];

  // Partial products: column c collects a[i] & b[c-i], lowest i in row 0.
  for (genvar gc = 0; gc < CW; gc++) begin : gen_pp_col
    localparam int LO = (gc > WIDTH - 1) ? gc - WIDTH + 1 : 0;
    localparam int H0 = dadda_col_height(WIDTH, 0, gc);
    for (genvar gr = 0; gr < WIDTH; gr++) begin : gen_pp_row
      if (gr < H0) begin : gen_bit
        assign mat[0][gc][gr] = a[LO+gr] & b[gc-LO-gr];
      end else begin : gen_zero
        assign mat[0][gc][gr] = 1'b0;
      end
    end
  end

  for (genvar gs = 0; gs < NS; gs++) begin : gen_stage
    for (genvar gc = 0; gc < CW; gc++) begin : gen_col
      localparam int H    = dadda_col_height(WIDTH, gs, gc);
      localparam int FA   = dadda_fa_count(WIDTH, gs, gc);
      localparam int HA   = dadda_ha_count(WIDTH, gs, gc);
      localparam int NA   = FA + HA;
      localparam int USED = 3 * FA + 2 * HA;
      localparam int KEEP = H - USED;
      localparam int CP   = dadda_fa_count(WIDTH, gs, gc - 1) +
                            dadda_ha_count(WIDTH, gs, gc - 1);
      localparam int PC   = (gc > 0) ? gc - 1 : 0;

      // Adders consume the lowest rows of the column; carries go one column up.
      for (genvar gk = 0; gk < WIDTH; gk++) begin : gen_add
        if (gk < FA) begin : gen_fa
          full_adder u_fa (
            .a  (mat[gs][gc][3*gk]),
            .b  (mat[gs][gc][3*gk+1]),
            .ci (mat[gs][gc][3*gk+2]),
            .sum(sm[gs][gc][gk]),
            .co (cy[gs][gc][gk])
          );
        end else if (gk < NA) begin : gen_ha
          half_adder u_ha (
            .a  (mat[gs][gc][3*FA+2*(gk-FA)]),
            .b  (mat[gs][gc][3*FA+2*(gk-FA)+1]),
            .sum(sm[gs][gc][gk]),
            .co (cy[gs][gc][gk])
          );
        end else begin : gen_none
          assign sm[gs][gc][gk] = 1'b0;
          assign cy[gs][gc][gk] = 1'b0;
        end
      end

      // Next column contents: untouched bits, then local sums, then incoming carries.
      for (genvar gr = 0; gr < WIDTH; gr++) begin : gen_next
        if (gr < KEEP) begin : gen_keep
          assign mat[gs+1][gc][gr] = mat[gs][gc][USED+gr];
        end else if (gr < KEEP + NA) begin : gen_sum
          assign mat[gs+1][gc][gr] = sm[gs][gc][gr-KEEP];
        end else if (gr < KEEP + NA + CP) begin : gen_carry
          assign mat[gs+1][gc][gr] = cy[gs][PC][gr-KEEP-NA];
        end else begin : gen_zero
          assign mat[gs+1][gc][gr] = 1'b0;
        end
      end
    end
  end

  for (genvar gc = 0; gc < CW; gc++) begin : gen_out
    assign row0[gc] = mat[NS][gc][0];
    assign row1[gc] = mat[NS][gc][1];
  end
endmodule

// File: rtl/dadda_mul_pipe.sv
// Three-stage streaming signed/unsigned multiplier with valid/ready on both
// sides: S1 magnitudes, S2 Dadda rows, S3 final add and sign fix-up.
module dadda_mul_pipe
  import dadda_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic [TAG_W-1:0]   out_tag
);
  localparam int PW = 2 * WIDTH;

  logic             en;
  logic             s1_valid, s2_valid, s3_valid;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic             neg_a, neg_b;
  logic [WIDTH-1:0] s1_abs_a, s1_abs_b;
  logic             s1_sign, s2_sign;
  logic [TAG_W-1:0] s1_tag, s2_tag;
  logic [PW-1:0]    red_row0, red_row1;
  logic [PW-1:0]    s2_row0, s2_row1;
  logic [PW-1:0]    raw_sum, fixed_sum;

  // The whole pipe freezes only when a finished result cannot leave.
  assign en        = !(s3_valid && !out_ready);
  assign in_ready  = en;
  assign out_valid = s3_valid;

  // Unary minus on WIDTH bits maps -2^(W-1) to 2^(W-1), which is its magnitude.
  assign neg_a = signed_mode & a[WIDTH-1];
  assign neg_b = signed_mode & b[WIDTH-1];
  assign abs_a = neg_a ? -a : a;
  assign abs_b = neg_b ? -b : b;

  // Valid bits advance together whenever the pipe is not stalled.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments so every stage samples the pre-edge value of the one before it.
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
    end else if (en) begin
      s1_valid <= in_valid;
      s2_valid <= s1_valid;
      s3_valid <= s2_valid;
    end
  end

  // S1: register operand magnitudes, result sign and tag.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: datapath registers are reset too, so outputs are never X after reset.
    if (rst) begin
      s1_abs_a <= '0;
      s1_abs_b <= '0;
      s1_sign  <= 1'b0;
      s1_tag   <= '0;
    end else if (en && in_valid) begin
      s1_abs_a <= abs_a;
      s1_abs_b <= abs_b;
      s1_sign  <= neg_a ^ neg_b;
      s1_tag   <= in_tag;
    end
  end

  dadda_reduce #(.WIDTH(WIDTH)) u_reduce (
    .a   (s1_abs_a),
    .b   (s1_abs_b),
    .row0(red_row0),
    .row1(red_row1)
  );

  // S2: register the two reduced rows alongside sign and tag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_row0 <= '0;
      s2_row1 <= '0;
      s2_sign <= 1'b0;
      s2_tag  <= '0;
    end else if (en && s1_valid) begin
      s2_row0 <= red_row0;
      s2_row1 <= red_row1;
      s2_sign <= s1_sign;
      s2_tag  <= s1_tag;
    end
  end

  kogge_stone_adder #(.WIDTH(PW)) u_final_add (
    .a  (s2_row0),
    .b  (s2_row1),
    .sum(raw_sum)
  );

  assign fixed_sum = (raw_sum ^ {PW{s2_sign}}) + PW'(s2_sign);

  // S3: register the signed product; it holds while no new result arrives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      product <= '0;
      out_tag <= '0;
    end else if (en && s2_valid) begin
      product <= fixed_sum;
      out_tag <= s2_tag;
    end
  end
endmodule

// File: tb/tb_dadda_mul_pipe.sv
// Self-checking bench for dadda_mul_pipe: literal corner products, a queue-based
// reference model checked on every output transfer, stalls and mid-flight reset.
module tb_dadda_mul_pipe;
  localparam int W     = 16;
  localparam int TAG_W = 4;

  typedef struct {
    logic [2*W-1:0]   p;
    logic [TAG_W-1:0] t;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic             signed_mode;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [2*W-1:0]   product;
  logic [TAG_W-1:0] out_tag;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_in     = 0;
  int   n_out    = 0;
  int   run_len  = 0;
  int   max_run  = 0;
  bit   drv_done;
  exp_t exp_q [$];

  logic             prev_stall = 1'b0;
  logic [2*W-1:0]   prev_p;
  logic [TAG_W-1:0] prev_t;

  dadda_mul_pipe #(.WIDTH(W), .TAG_W(TAG_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .signed_mode(signed_mode),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .product    (product),
    .out_tag    (out_tag)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: exact integer product of the operands read as signed or unsigned.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic sm, input logic [TAG_W-1:0] t);
    longint sx, sy, pr;
    exp_t   r;
    sx  = sm ? longint'($signed(x)) : longint'({1'b0, x});
    sy  = sm ? longint'($signed(y)) : longint'({1'b0, y});
    pr  = sx * sy;
    r.p = pr[2*W-1:0];
    r.t = t;
    return r;
  endfunction

  function automatic logic [W-1:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return {1'b1, {(W-1){1'b0}}};
      3:       return {1'b0, {(W-1){1'b1}}};
      default: return W'($urandom);
    endcase
  endfunction

  // Monitor: protocol rules, stall stability and scoreboard on every transfer.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_stall = 1'b0;
      run_len    = 0;
    end else begin
      check("in_ready_rule", in_ready, !(out_valid && !out_ready));
      if (prev_stall) begin
        check("stall_valid_hold", out_valid, 1);
        check("stall_product_hold", product, prev_p);
        check("stall_tag_hold", out_tag, prev_t);
      end
      if (out_valid && out_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_unexpected: product 0x%0h tag %0d with nothing outstanding", product, out_tag);
        end else begin
          e = exp_q.pop_front();
          check("sb_product", product, e.p);
          check("sb_tag", out_tag, e.t);
        end
      end
      run_len = out_valid ? run_len + 1 : 0;
      if (run_len > max_run) max_run = run_len;
      if (in_valid && in_ready) begin
        n_in++;
        exp_q.push_back(model(a, b, signed_mode, in_tag));
      end
      prev_stall = out_valid && !out_ready;
      prev_p     = product;
      prev_t     = out_tag;
    end
  end

  // Present one operation (called at posedge+1) and hold it until accepted.
  task automatic send_op(input logic [W-1:0] x, input logic [W-1:0] y,
                         input logic sm, input logic [TAG_W-1:0] t);
    int   guard;
    logic acc;
    a = x; b = y; signed_mode = sm; in_tag = t; in_valid = 1'b1;
    guard = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      guard++;
    end while (!acc && guard < 200);
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", guard);
    end
    in_valid = 1'b0;
  endtask

  // Single isolated op: latency must be 3 and result must match a literal.
  task automatic run_single(input logic [W-1:0] x, input logic [W-1:0] y, input logic sm,
                            input logic [TAG_W-1:0] t, input logic [2*W-1:0] exp_p);
    int cnt;
    send_op(x, y, sm, t);
    cnt = 1;
    while (!out_valid && cnt < 10) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    check("single_latency", cnt, 3);
    check("single_product", product, exp_p);
    check("single_tag", out_tag, t);
  endtask

  task automatic wait_drain();
    int g;
    g = 0;
    while ((exp_q.size() != 0 || out_valid) && g < 200) begin
      @(posedge clk);
      #1;
      g++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic mode0;
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; signed_mode = 1'b0;
    in_tag = '0; out_ready = 1'b1;

    #12;
    check("reset_out_valid", out_valid, 0);
    check("reset_product", product, 0);
    check("reset_out_tag", out_tag, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("reset_in_ready", in_ready, 1);

    // Corner products against hand-computed constants.
    run_single(16'h8000, 16'h8000, 1'b1, 4'd5, 32'h4000_0000);
    run_single(16'hFFFF, 16'h0001, 1'b1, 4'd6, 32'hFFFF_FFFF);
    run_single(16'hFFFF, 16'h0001, 1'b0, 4'd7, 32'h0000_FFFF);
    run_single(16'hFFFF, 16'hFFFF, 1'b0, 4'd8, 32'hFFFE_0001);
    run_single(16'h7FFF, 16'h8000, 1'b1, 4'd9, 32'hC000_8000);
    run_single(16'h8000, 16'h8000, 1'b0, 4'd10, 32'h4000_0000);
    run_single(16'hFFFF, 16'hFFFF, 1'b1, 4'd11, 32'h0000_0001);
    run_single(16'd0,    16'hFFFF, 1'b1, 4'd12, 32'h0000_0000);
    wait_drain();

    // Eight back-to-back ops with alternating mode: one unbroken run of 8 results.
    max_run = 0;
    mode0   = 1'($urandom);
    for (int i = 0; i < 8; i++)
      send_op(pick_operand(), pick_operand(), mode0 ^ i[0], TAG_W'(i));
    wait_drain();
    check("b2b_run_len", max_run, 8);

    // Stall with three ops in flight and a fourth waiting at the input.
    for (int i = 0; i < 3; i++)
      send_op(pick_operand(), pick_operand(), 1'($urandom), TAG_W'(i + 3));
    out_ready = 1'b0;
    a = 16'h1234; b = 16'hFEDC; signed_mode = 1'b1; in_tag = 4'hA; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_in_ready", in_ready, 0);
      check("stall_out_valid", out_valid, 1);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send_op(16'h1234, 16'hFEDC, 1'b1, 4'hA);
    wait_drain();
    check("stall_no_loss", n_out, n_in);

    // Long random stream with random input gaps and random backpressure.
    drv_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
          end
          send_op(pick_operand(), pick_operand(), 1'($urandom), TAG_W'($urandom));
        end
        drv_done = 1'b1;
      end
      begin
        while (!drv_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();
    check("stream_count", n_out, n_in);

    // Reset with two ops in flight: outputs clear at once, nothing stale follows.
    send_op(16'h1234, 16'h0056, 1'b0, 4'd1);
    send_op(16'h00FF, 16'h0003, 1'b1, 4'd2);
    @(posedge clk); #1;
    check("pre_reset_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    check("async_reset_valid", out_valid, 0);
    check("async_reset_product", product, 0);
    check("async_reset_tag", out_tag, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("post_reset_in_ready", in_ready, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_reset_idle", out_valid, 0);
    end
    @(posedge clk); #1;
    run_single(16'd3, 16'd4, 1'b0, 4'd7, 32'd12);
    wait_drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
